// File: rtl/bip_control_unit.sv
// Instruction sequencer for the accumulator datapath: FETCH/DECODE/EXEC per instruction, HALT terminal.
// Optional executed-instruction counter (o_instr_count) is built when BIP_INSTR_COUNT_EN is defined.
//
// state  | meaning
// FETCH  | o_addr_pm = PC, sync ROM is reading the instruction
// DECODE | i_instr valid; decode from it, RdRam for LD/ADD/SUB, IR captured
// EXEC   | WrAcc/WrRam per opcode, PC advances (HLT holds PC)
// HALT   | frozen until reset, o_halted = 1
module bip_control_unit #(
    parameter int PB = 11,
    parameter int AB = 11,
    parameter int DB = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DB-1:0] i_instr,
    output logic [PB-1:0] o_addr_pm,
    output logic [AB-1:0] o_addr,
    output logic [1:0]    o_sel_a,
    output logic          o_sel_b,
    output logic          o_op,
    output logic          o_wr_acc,
    output logic          o_clear,
    output logic          o_wr_ram,
    output logic          o_rd_ram,
`ifdef BIP_INSTR_COUNT_EN
    output logic [31:0]   o_instr_count,
`endif
    output logic          o_halted
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    state_t        r_state;
    state_t        w_next_state;
    logic [PB-1:0] r_pc;
    logic [DB-1:0] r_ir;
    logic [DB-1:0] w_cur;
    logic [4:0]    w_opc;
    logic          w_dec_wr_acc;
    logic          w_dec_wr_ram;
    logic          w_dec_rd_ram;
`ifdef BIP_INSTR_COUNT_EN
    logic [31:0]   r_instr_count;
`endif

    // IR is only loaded at the end of DECODE, so DECODE looks at the ROM output directly;
    // this keeps SelA/SelB/Op/Addr identical across DECODE and EXEC.
    assign w_cur = (r_state == S_DECODE) ? i_instr : r_ir;
    assign w_opc = w_cur[DB-1:DB-5];

    always_comb begin
        o_sel_a      = 2'd0;
        o_sel_b      = 1'b0;
        o_op         = 1'b0;
        w_dec_wr_acc = 1'b0;
        w_dec_wr_ram = 1'b0;
        w_dec_rd_ram = 1'b0;
        case (w_opc)
            OP_STO:  w_dec_wr_ram = 1'b1;
            OP_LD: begin
                o_sel_a      = 2'd2;
                w_dec_wr_acc = 1'b1;
                w_dec_rd_ram = 1'b1;
            end
            OP_LDI: begin
                o_sel_a      = 2'd1;
                w_dec_wr_acc = 1'b1;
            end
            OP_ADD: begin
                o_sel_b      = 1'b1;
                o_op         = 1'b1;
                w_dec_wr_acc = 1'b1;
                w_dec_rd_ram = 1'b1;
            end
            OP_ADDI: begin
                o_op         = 1'b1;
                w_dec_wr_acc = 1'b1;
            end
            OP_SUB: begin
                o_sel_b      = 1'b1;
                w_dec_wr_acc = 1'b1;
                w_dec_rd_ram = 1'b1;
            end
            OP_SUBI: w_dec_wr_acc = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        o_wr_acc     = 1'b0;
        o_wr_ram     = 1'b0;
        o_rd_ram     = 1'b0;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                w_next_state = S_EXEC;
                o_rd_ram     = w_dec_rd_ram && !i_reset;
            end
            S_EXEC: begin
                w_next_state = (w_opc == OP_HLT) ? S_HALT : S_FETCH;
                // Reset drops the strobe in the same cycle so no stray memory write happens.
                o_wr_acc     = w_dec_wr_acc && !i_reset;
                o_wr_ram     = w_dec_wr_ram && !i_reset;
            end
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE)
                r_ir <= i_instr;
            if (r_state == S_EXEC && w_opc != OP_HLT)
                r_pc <= r_pc + PB'(1);
        end
    end

`ifdef BIP_INSTR_COUNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_instr_count <= '0;
        else if (r_state == S_EXEC && r_instr_count != 32'hFFFF_FFFF)
            r_instr_count <= r_instr_count + 32'd1;
    end

    assign o_instr_count = r_instr_count;
`endif

    assign o_addr_pm = r_pc;
    assign o_addr    = w_cur[AB-1:0];
    assign o_clear   = i_reset;
    assign o_halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: sync ROM, data RAM and accumulator datapath around the sequencer,
// with an ISA-level model filling a per-instruction scoreboard of expected strobes and decode.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic [10:0] addr_pm;
    logic [10:0] addr;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, clear, wr_ram, rd_ram, halted;
`ifdef BIP_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    bip_control_unit dut (
        .i_clk(clk), .i_reset(reset), .i_instr(instr),
        .o_addr_pm(addr_pm), .o_addr(addr), .o_sel_a(sel_a), .o_sel_b(sel_b), .o_op(op),
        .o_wr_acc(wr_acc), .o_clear(clear), .o_wr_ram(wr_ram), .o_rd_ram(rd_ram),
`ifdef BIP_INSTR_COUNT_EN
        .o_instr_count(instr_count),
`endif
        .o_halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] rom   [2048];
    logic [15:0] d_ram [2048];
    logic [15:0] m_ram [2048];
    logic [15:0] acc = '0;
    logic [15:0] ram_q = '0;
    logic [15:0] acc_next;
    logic [15:0] alu_b;
    logic        tb_wr = 1'b0;
    logic [10:0] tb_wa = '0;
    logic [15:0] tb_wd = '0;
    logic [15:0] m_acc;

    function automatic logic [15:0] sext(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    always_comb begin
        alu_b = sel_b ? ram_q : sext(addr);
        case (sel_a)
            2'd0:    acc_next = op ? acc + alu_b : acc - alu_b;
            2'd1:    acc_next = sext(addr);
            2'd2:    acc_next = ram_q;
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        instr <= rom[addr_pm];
        if (rd_ram) ram_q <= d_ram[addr];
        if (wr_ram) d_ram[addr] <= acc;
        if (tb_wr) d_ram[tb_wa] <= tb_wd;
        if (clear) acc <= '0;
        else if (wr_acc) acc <= acc_next;
    end

    typedef struct {
        logic [10:0] pc;
        logic [10:0] opnd;
        logic        rd, wa, wr;
        logic [1:0]  sa;
        logic        sb, op;
        bit          hlt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic [10:0] last_pc;

    task automatic load_rom(input logic [15:0] prog[$], input logic [15:0] fill);
        for (int i = 0; i < 2048; i++) rom[i] = fill;
        foreach (prog[i]) rom[i] = prog[i];
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        tb_wr = 1'b1; tb_wa = a; tb_wd = d;
        m_ram[a] = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    // ISA-level reference: walks the program, updating its own RAM/accumulator copy.
    task automatic build_sb(input int n_max);
        logic [10:0] pc;
        logic [15:0] w;
        exp_t e;
        pc = '0;
        m_acc = '0;
        sb_q.delete();
        for (int i = 0; i < n_max; i++) begin
            w = rom[pc];
            e = '{pc: pc, opnd: w[10:0], rd: 1'b0, wa: 1'b0, wr: 1'b0, sa: 2'd0, sb: 1'b0, op: 1'b0, hlt: 1'b0};
            case (w[15:11])
                5'd0: e.hlt = 1'b1;
                5'd1: begin e.wr = 1'b1; m_ram[w[10:0]] = m_acc; end
                5'd2: begin e.rd = 1'b1; e.wa = 1'b1; e.sa = 2'd2; m_acc = m_ram[w[10:0]]; end
                5'd3: begin e.wa = 1'b1; e.sa = 2'd1; m_acc = sext(w[10:0]); end
                5'd4: begin e.rd = 1'b1; e.wa = 1'b1; e.sb = 1'b1; e.op = 1'b1; m_acc = m_acc + m_ram[w[10:0]]; end
                5'd5: begin e.wa = 1'b1; e.op = 1'b1; m_acc = m_acc + sext(w[10:0]); end
                5'd6: begin e.rd = 1'b1; e.wa = 1'b1; e.sb = 1'b1; m_acc = m_acc - m_ram[w[10:0]]; end
                5'd7: begin e.wa = 1'b1; m_acc = m_acc - sext(w[10:0]); end
                default: ;
            endcase
            sb_q.push_back(e);
            if (e.hlt) break;
            pc = pc + 11'd1;
        end
    endtask

    // Consumes scoreboard entries, one instruction (FETCH, DECODE, EXEC) per entry.
    task automatic run_sb(input int max_instr);
        exp_t e;
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < max_instr) begin
            e = sb_q.pop_front();
            n++;
            last_pc = e.pc;
            #1;
            n_checks++;
            if ({addr_pm, wr_acc, wr_ram, rd_ram, halted} !== {e.pc, 4'b0000})
                $display("FAIL fetch pc=%0h: got pc/wa/wr/rd/h=%0h/%b%b%b%b exp %0h/0000",
                         e.pc, addr_pm, wr_acc, wr_ram, rd_ram, halted, e.pc);
            else n_pass++;
            @(negedge clk); #1;
            n_checks++;
            if ({rd_ram, wr_acc, wr_ram, addr, sel_a, sel_b, op} !== {e.rd, 2'b00, e.opnd, e.sa, e.sb, e.op})
                $display("FAIL decode pc=%0h: got rd=%b wa=%b wr=%b addr=%0h sa=%0d sb=%b op=%b exp rd=%b addr=%0h sa=%0d sb=%b op=%b",
                         e.pc, rd_ram, wr_acc, wr_ram, addr, sel_a, sel_b, op, e.rd, e.opnd, e.sa, e.sb, e.op);
            else n_pass++;
            @(negedge clk); #1;
            n_checks++;
            if ({wr_acc, wr_ram, rd_ram, addr, sel_a, sel_b, op, addr_pm, halted} !==
                {e.wa, e.wr, 1'b0, e.opnd, e.sa, e.sb, e.op, e.pc, 1'b0})
                $display("FAIL exec pc=%0h: got wa=%b wr=%b rd=%b addr=%0h sa=%0d sb=%b op=%b apm=%0h exp wa=%b wr=%b addr=%0h sa=%0d sb=%b op=%b",
                         e.pc, wr_acc, wr_ram, rd_ram, addr, sel_a, sel_b, op, addr_pm, e.wa, e.wr, e.opnd, e.sa, e.sb, e.op);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        else n_pass++;
    endtask

    task automatic check_halted(input logic [10:0] hlt_pc);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({halted, addr_pm, wr_acc, wr_ram, rd_ram} !== {1'b1, hlt_pc, 3'b000})
                $display("FAIL halt_hold: got h=%b apm=%0h strobes=%b%b%b exp h=1 apm=%0h strobes=000",
                         halted, addr_pm, wr_acc, wr_ram, rd_ram, hlt_pc);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] prog[$];
        prog = {16'h0000};
        load_rom(prog, 16'h0000);
        hold_reset();
        #1;
        n_checks++;
        if ({addr_pm, addr, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted, clear} !== {11'd0, 11'd0, 7'b0000000, 1'b1})
            $display("FAIL reset_values: got apm=%0h addr=%0h sa=%0d sb=%b op=%b wa=%b wr=%b rd=%b h=%b clr=%b exp zeros, clr=1",
                     addr_pm, addr, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted, clear);
        else n_pass++;
        release_reset();
        #1;
        n_checks++;
        if ({clear, halted, addr_pm} !== {2'b00, 11'd0})
            $display("FAIL reset_release: got clr=%b h=%b apm=%0h exp 0 0 0", clear, halted, addr_pm);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ldi_addi_sto();
        logic [15:0] prog[$];
        prog = {16'h1805, 16'h2803, 16'h0810, 16'h0000};
        load_rom(prog, 16'h0000);
        hold_reset();
        poke(11'h010, 16'hDEAD);
        build_sb(16);
        release_reset();
        run_sb(16);
        check_halted(11'd3);
        n_checks++;
        if ({d_ram[11'h010], m_ram[11'h010]} !== {16'd8, 16'd8})
            $display("FAIL sto_data: got ram[0x10]=%0d model=%0d exp 8", d_ram[11'h010], m_ram[11'h010]);
        else n_pass++;
    endtask

    task automatic test_ld_sub();
        logic [15:0] prog[$];
        prog = {16'h1020, 16'h3021, 16'h0000};
        load_rom(prog, 16'h0000);
        hold_reset();
        poke(11'h020, 16'd10);
        poke(11'h021, 16'd4);
        build_sb(16);
        release_reset();
        run_sb(16);
        check_halted(11'd2);
        n_checks++;
        if (acc !== 16'd6 || m_acc !== 16'd6)
            $display("FAIL ld_sub_acc: got acc=%0d model=%0d exp 6", acc, m_acc);
        else n_pass++;
    endtask

    task automatic test_mixed();
        logic [15:0] prog[$];
        // LDI -1, ADD [0x20], undefined 01000, SUBI 2, STO 0x011, LD 0x011, HLT
        prog = {16'h1FFF, 16'h2020, 16'h4005, 16'h3802, 16'h0811, 16'h1011, 16'h0000};
        load_rom(prog, 16'h0000);
        hold_reset();
        poke(11'h020, 16'd10);
        poke(11'h011, 16'h5555);
        build_sb(16);
        release_reset();
        run_sb(16);
        check_halted(11'd6);
        n_checks++;
        if ({d_ram[11'h011], acc} !== {16'd7, 16'd7})
            $display("FAIL mixed_result: got ram[0x11]=%0d acc=%0d exp 7 7", d_ram[11'h011], acc);
        else n_pass++;
    endtask

    task automatic test_nop_wrap();
        logic [15:0] prog[$];
        prog = {};
        load_rom(prog, 16'hF800);
        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800 | 16'(i[10:0]);
        hold_reset();
        build_sb(2050);
        release_reset();
        run_sb(2050);
        #1;
        n_checks++;
        if ({addr_pm, halted, wr_acc, wr_ram} !== {11'd2, 3'b000})
            $display("FAIL nop_wrap: got apm=%0h h=%b wa=%b wr=%b exp apm=2 all 0", addr_pm, halted, wr_acc, wr_ram);
        else n_pass++;
        n_checks++;
        if (acc !== 16'd0)
            $display("FAIL nop_acc: got acc=%0h exp 0", acc);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        logic [15:0] prog[$];
        prog = {16'h1807, 16'h0830, 16'h0000};
        load_rom(prog, 16'h0000);
        hold_reset();
        poke(11'h030, 16'h1234);
        release_reset();
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if ({wr_ram, addr, addr_pm} !== {1'b1, 11'h030, 11'd1})
            $display("FAIL sto_exec_pre: got wr=%b addr=%0h apm=%0h exp 1 30 1", wr_ram, addr, addr_pm);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wr_ram, wr_acc, clear} !== 3'b001)
            $display("FAIL reset_exec_strobe: got wr=%b wa=%b clr=%b exp 0 0 1", wr_ram, wr_acc, clear);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({addr_pm, halted, d_ram[11'h030], acc} !== {11'd0, 1'b0, 16'h1234, 16'd0})
            $display("FAIL reset_exec_after: got apm=%0h h=%b ram[0x30]=%0h acc=%0h exp 0 0 1234 0",
                     addr_pm, halted, d_ram[11'h030], acc);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef BIP_INSTR_COUNT_EN
    task automatic test_instr_count();
        logic [15:0] prog[$];
        prog = {16'h1801, 16'h2801, 16'h0000};
        load_rom(prog, 16'h0000);
        hold_reset();
        #1;
        n_checks++;
        if (instr_count !== 32'd0)
            $display("FAIL count_reset: got %0d exp 0", instr_count);
        else n_pass++;
        build_sb(16);
        release_reset();
        run_sb(16);
        check_halted(11'd2);
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if ({instr_count, acc} !== {32'd3, 16'd2})
            $display("FAIL count_halt: got count=%0d acc=%0d exp 3 2", instr_count, acc);
        else n_pass++;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) begin
            rom[i] = '0;
            m_ram[i] = '0;
        end
        test_reset();
        test_ldi_addi_sto();
        test_ld_sub();
        test_mixed();
        test_reset_mid_exec();
        test_nop_wrap();
`ifdef BIP_INSTR_COUNT_EN
        test_instr_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
